// File: rtl/pcm_mic_deserializer_pkg.sv
// Shared defaults and FSM encoding for the PCM microphone capture path.
package pcm_mic_deserializer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_FRAME_BITS = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } mic_state_e;

endpackage

// File: rtl/pcm_sample_fifo.sv
// First-word fall-through sample FIFO; writes into a full FIFO are dropped and flagged.
module pcm_sample_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    input  logic                  clr_ovf,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid,
    output logic                  overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  do_rd;
    logic                  do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_wr = wr && (!full || do_rd);

    assign valid   = !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (wr && !do_wr) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcm_mic_deserializer.sv
// I2S-style microphone capture: drives WS from the divider's BCLK, shifts mic data
// MSB first and queues completed samples in a small FIFO.
module pcm_mic_deserializer
    import pcm_mic_deserializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN_CLK,
    input  logic                  BCLK,
    input  logic                  MIC_DATA,
    output logic                  WS,
    output logic [DATA_WIDTH-1:0] SAMPLE,
    output logic                  SAMPLE_VALID,
    input  logic                  SAMPLE_RD,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVF
);

    localparam int unsigned   CW        = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] DW_CNT    = CW'(DATA_WIDTH);

    mic_state_e            state;
    mic_state_e            state_next;
    logic                  mic_meta;
    logic                  mic_s;
    logic                  bclk_q;
    logic                  rise;
    logic                  fall;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         cnt_next;
    logic [DATA_WIDTH-1:0] shift;
    logic                  take;
    logic                  wr_q;

    assign rise = BCLK && !bclk_q;
    assign fall = !BCLK && bclk_q;
    assign take = (state == ST_RUN) && EN_CLK && rise && (bit_cnt < DW_CNT);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (EN_CLK) state_next = ST_ALIGN;
            ST_ALIGN: if (fall)   state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
        if (!EN_CLK) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        cnt_next = bit_cnt;
        if (state_next == ST_IDLE) begin
            cnt_next = '0;
        end else if (state == ST_ALIGN && fall) begin
            cnt_next = '0;
        end else if (state == ST_RUN && fall) begin
            cnt_next = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mic_meta <= 1'b0;
            mic_s    <= 1'b0;
            bclk_q   <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
            WS       <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            mic_meta <= MIC_DATA;
            mic_s    <= mic_meta;
            bclk_q   <= BCLK;
            bit_cnt  <= cnt_next;
            // WS follows the counter value it is about to hold, so it spans the whole last bit.
            WS       <= (state_next == ST_RUN) && (cnt_next == LAST_BIT);
            wr_q     <= take && (bit_cnt == LAST_DATA);
            if (state_next == ST_IDLE) begin
                shift <= '0;
            end else if (take) begin
                shift <= DATA_WIDTH'({shift, mic_s});
            end
        end
    end

    pcm_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RESET),
        .wr       (wr_q),
        .wr_data  (shift),
        .rd       (SAMPLE_RD),
        .clr_ovf  (CLR_OVF),
        .rd_data  (SAMPLE),
        .valid    (SAMPLE_VALID),
        .overflow (OVERFLOW)
    );

endmodule
